// File: rtl/ast_mac_pipe_if.sv
// Bus bundle for the ast_mac_pipe processing element: operand stream in,
// forwarded operands out, and the dot-product result handshake.
interface ast_mac_pipe_if #(
  parameter int DATAWIDTH = 14,
  parameter int ACCWIDTH  = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a_in;
  logic [DATAWIDTH-1:0] b_in;
  logic                 signed_mode;
  logic [DATAWIDTH-1:0] a_out;
  logic [DATAWIDTH-1:0] b_out;
  logic                 fwd_valid;
  logic [ACCWIDTH-1:0]  acc_out;
  logic                 overflow;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output in_valid, a_in, b_in, signed_mode, res_ready,
    input  in_ready, a_out, b_out, fwd_valid, acc_out, overflow, res_valid
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_mode, res_ready,
    output in_ready, a_out, b_out, fwd_valid, acc_out, overflow, res_valid
  );
endinterface

// File: rtl/ast_mac_pipe.sv
// Three-stage pipelined MAC PE: operand register, product, accumulate.
// Define AST_MAC_SAT_EN for saturating accumulation with a sticky overflow flag.
module ast_mac_pipe #(
  parameter int DATAWIDTH = 14,
  parameter int ACCWIDTH  = 32,
  parameter int K_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           reset,
  ast_mac_pipe_if.slave  bus
);
  localparam int CNT_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int PW    = 2 * DATAWIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_DEPTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. Inputs transfer on in_valid & in_ready; results on res_valid & res_ready.
  // A pending unconsumed result freezes the whole pipeline (in_ready = ~stall).
  logic stall, accept, first, last, fire3;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d, s1_sgn_q, s1_sgn_d;
  logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                 s2_valid_q, s2_valid_d, s2_first_q, s2_first_d;
  logic                 s2_last_q, s2_last_d, s2_sgn_q, s2_sgn_d;
  logic [ACCWIDTH-1:0]  s2_prod_q, s2_prod_d;
  logic [ACCWIDTH-1:0]  acc_q, acc_d, acc_out_q, acc_out_d;
  logic                 res_valid_q, res_valid_d;

  logic signed [PW-1:0] a_w, b_w, p_s;
  logic [ACCWIDTH-1:0]  prod_ext, base, acc_new;

`ifdef AST_MAC_SAT_EN
  logic [ACCWIDTH:0]    sum;
  logic [ACCWIDTH-1:0]  clamp;
  logic                 sat;
  logic                 ov_q, ov_d, overflow_q, overflow_d;
`endif

  assign stall  = res_valid_q & ~bus.res_ready & ~reset;
  assign accept = bus.in_valid & ~stall;
  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == LAST_CNT);
  assign fire3  = s2_valid_q & ~stall;

  // Operands are widened by one bit so the same signed multiplier serves both modes.
  always_comb begin
    a_w      = PW'($signed({s1_sgn_q & a_q[DATAWIDTH-1], a_q}));
    b_w      = PW'($signed({s1_sgn_q & b_q[DATAWIDTH-1], b_q}));
    p_s      = a_w * b_w;
    prod_ext = s1_sgn_q ? ACCWIDTH'(p_s) : ACCWIDTH'($unsigned(p_s));
    base     = s2_first_q ? '0 : acc_q;
`ifdef AST_MAC_SAT_EN
    if (s2_sgn_q) begin
      sum   = {base[ACCWIDTH-1], base} + {s2_prod_q[ACCWIDTH-1], s2_prod_q};
      sat   = sum[ACCWIDTH] ^ sum[ACCWIDTH-1];
      clamp = sum[ACCWIDTH] ? {1'b1, {(ACCWIDTH-1){1'b0}}} : {1'b0, {(ACCWIDTH-1){1'b1}}};
    end else begin
      sum   = {1'b0, base} + {1'b0, s2_prod_q};
      sat   = sum[ACCWIDTH];
      clamp = '1;
    end
    acc_new = sat ? clamp : sum[ACCWIDTH-1:0];
`else
    acc_new = base + s2_prod_q;
`endif
  end

  always_comb begin
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_sgn_d    = s1_sgn_q;
    a_d         = a_q;
    b_d         = b_q;
    s2_valid_d  = s2_valid_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_sgn_d    = s2_sgn_q;
    s2_prod_d   = s2_prod_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    res_valid_d = res_valid_q;
`ifdef AST_MAC_SAT_EN
    ov_d        = ov_q;
    overflow_d  = overflow_q;
`endif
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        cnt_d      = last ? '0 : cnt_q + CNT_W'(1);
        a_d        = bus.a_in;
        b_d        = bus.b_in;
        s1_first_d = first;
        s1_last_d  = last;
        s1_sgn_d   = first ? bus.signed_mode : s1_sgn_q;
      end
      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_sgn_d   = s1_sgn_q;
      s2_prod_d  = prod_ext;
    end
    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
    if (fire3) begin
      acc_d = acc_new;
`ifdef AST_MAC_SAT_EN
      ov_d  = (s2_first_q ? 1'b0 : ov_q) | sat;
`endif
      if (s2_last_q) begin
        acc_out_d   = acc_new;
        res_valid_d = 1'b1;
`ifdef AST_MAC_SAT_EN
        overflow_d  = (s2_first_q ? 1'b0 : ov_q) | sat;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sgn_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sgn_q    <= 1'b0;
      s2_prod_q   <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      res_valid_q <= 1'b0;
`ifdef AST_MAC_SAT_EN
      ov_q        <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_sgn_q    <= s1_sgn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_sgn_q    <= s2_sgn_d;
      s2_prod_q   <= s2_prod_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      res_valid_q <= res_valid_d;
`ifdef AST_MAC_SAT_EN
      ov_q        <= ov_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.fwd_valid = s1_valid_q & ~stall;
  assign bus.acc_out   = acc_out_q;
  assign bus.res_valid = res_valid_q;
`ifdef AST_MAC_SAT_EN
  assign bus.overflow  = overflow_q;
`else
  assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_ast_mac_pipe.sv
// Directed bench for ast_mac_pipe: four PE configurations share one stimulus
// driver; each has a result scoreboard checked when a result is consumed.
module tb_ast_mac_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        v_drv, sm_drv, rr_drv;
  logic [13:0] a_drv, b_drv;
  int          sel;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        cur_ready;

  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  logic [32:0] exp_qc[$];
  logic [32:0] exp_qd[$];
  int          d_cyc[$];

  ast_mac_pipe_if #(.DATAWIDTH(14), .ACCWIDTH(32)) if_a ();
  ast_mac_pipe_if #(.DATAWIDTH(14), .ACCWIDTH(32)) if_b ();
  ast_mac_pipe_if #(.DATAWIDTH(4),  .ACCWIDTH(8))  if_c ();
  ast_mac_pipe_if #(.DATAWIDTH(14), .ACCWIDTH(32)) if_d ();

  ast_mac_pipe #(.DATAWIDTH(14), .ACCWIDTH(32), .K_DEPTH(4)) u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  ast_mac_pipe #(.DATAWIDTH(14), .ACCWIDTH(32), .K_DEPTH(2)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  ast_mac_pipe #(.DATAWIDTH(4),  .ACCWIDTH(8),  .K_DEPTH(4)) u_c (.clk(clk), .reset(reset), .bus(if_c.slave));
  ast_mac_pipe #(.DATAWIDTH(14), .ACCWIDTH(32), .K_DEPTH(1)) u_d (.clk(clk), .reset(reset), .bus(if_d.slave));

  assign if_a.in_valid = v_drv & (sel == 0);
  assign if_b.in_valid = v_drv & (sel == 1);
  assign if_c.in_valid = v_drv & (sel == 2);
  assign if_d.in_valid = v_drv & (sel == 3);
  assign if_a.a_in = a_drv;       assign if_a.b_in = b_drv;
  assign if_b.a_in = a_drv;       assign if_b.b_in = b_drv;
  assign if_c.a_in = a_drv[3:0];  assign if_c.b_in = b_drv[3:0];
  assign if_d.a_in = a_drv;       assign if_d.b_in = b_drv;
  assign if_a.signed_mode = sm_drv;  assign if_b.signed_mode = sm_drv;
  assign if_c.signed_mode = sm_drv;  assign if_d.signed_mode = sm_drv;
  assign if_a.res_ready = rr_drv;    assign if_b.res_ready = rr_drv;
  assign if_c.res_ready = rr_drv;    assign if_d.res_ready = rr_drv;

  always_comb begin
    case (sel)
      0:       cur_ready = if_a.in_ready;
      1:       cur_ready = if_b.in_ready;
      2:       cur_ready = if_c.in_ready;
      default: cur_ready = if_d.in_ready;
    endcase
  end

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver: present a pair, return 1 ns after the edge that accepted it
  task automatic send(input int s, input logic [13:0] a, input logic [13:0] b, input logic sm);
    int guard;
    guard = 0;
    sel = s; a_drv = a; b_drv = b; sm_drv = sm; v_drv = 1'b1;
    while (!cur_ready && guard < 50) begin
      tick(1);
      guard++;
    end
    chk("accept_within_bound", 33'(cur_ready), 33'd1);
    tick(1);
  endtask

  // scoreboards: compare on every consumed result
  always @(negedge clk) begin
    if (!reset && if_a.res_valid && if_a.res_ready) begin
      chk("a_sb_nonempty", 33'(exp_qa.size() != 0), 33'd1);
      if (exp_qa.size() != 0) chk("a_result", {if_a.overflow, if_a.acc_out}, exp_qa.pop_front());
    end
    if (!reset && if_b.res_valid && if_b.res_ready) begin
      chk("b_sb_nonempty", 33'(exp_qb.size() != 0), 33'd1);
      if (exp_qb.size() != 0) chk("b_result", {if_b.overflow, if_b.acc_out}, exp_qb.pop_front());
    end
    if (!reset && if_c.res_valid && if_c.res_ready) begin
      chk("c_sb_nonempty", 33'(exp_qc.size() != 0), 33'd1);
      if (exp_qc.size() != 0) chk("c_result", {if_c.overflow, 24'd0, if_c.acc_out}, exp_qc.pop_front());
    end
    if (!reset && if_d.res_valid && if_d.res_ready) begin
      chk("d_sb_nonempty", 33'(exp_qd.size() != 0), 33'd1);
      if (exp_qd.size() != 0) chk("d_result", {if_d.overflow, if_d.acc_out}, exp_qd.pop_front());
      d_cyc.push_back(cyc);
    end
  end

  initial begin
    int guard;
    reset = 1'b1; v_drv = 1'b0; sm_drv = 1'b0; rr_drv = 1'b1;
    a_drv = '0; b_drv = '0; sel = 0;
    tick(2);
    chk("rst_in_ready_during", 33'(if_a.in_ready), 33'd1);
    chk("rst_a_out", 33'(if_a.a_out), 33'd0);
    chk("rst_b_out", 33'(if_a.b_out), 33'd0);
    chk("rst_acc_out", {if_a.overflow, if_a.acc_out}, 33'd0);
    chk("rst_res_valid", 33'(if_a.res_valid), 33'd0);
    chk("rst_fwd_valid", 33'(if_a.fwd_valid), 33'd0);
    reset = 1'b0;
    tick(1);
    chk("rst_in_ready_after", 33'(if_a.in_ready), 33'd1);

    // basic unsigned vector, forwarding and result latency
    exp_qa.push_back({1'b0, 32'd130});
    send(0, 14'd3, 14'd5, 1'b0);
    chk("fwd_a0", {if_a.fwd_valid, 18'd0, if_a.a_out}, {1'b1, 18'd0, 14'd3});
    chk("fwd_b0", 33'(if_a.b_out), 33'd5);
    send(0, 14'd2, 14'd7, 1'b0);
    chk("fwd_a1", {if_a.fwd_valid, 18'd0, if_a.a_out}, {1'b1, 18'd0, 14'd2});
    chk("fwd_b1", 33'(if_a.b_out), 33'd7);
    send(0, 14'd1, 14'd1, 1'b0);
    send(0, 14'd10, 14'd10, 1'b0);
    v_drv = 1'b0;
    chk("fwd_b3", {if_a.fwd_valid, 18'd0, if_a.b_out}, {1'b1, 18'd0, 14'd10});
    chk("lat_e0", 33'(if_a.res_valid), 33'd0);
    tick(1);
    chk("lat_e1", 33'(if_a.res_valid), 33'd0);
    chk("fwd_drop", 33'(if_a.fwd_valid), 33'd0);
    tick(1);
    chk("lat_e2", {if_a.res_valid, if_a.acc_out}, {1'b1, 32'd130});
    tick(1);
    chk("lat_pulse", 33'(if_a.res_valid), 33'd0);

    // reset mid-vector
    send(0, 14'd7, 14'd7, 1'b0);
    send(0, 14'd9, 14'd9, 1'b0);
    v_drv = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrst_fwd", 33'(if_a.fwd_valid), 33'd0);
    exp_qa.push_back({1'b0, 32'd4});
    for (int i = 0; i < 4; i++) send(0, 14'd1, 14'd1, 1'b0);
    v_drv = 1'b0;
    tick(4);

    // signed vector; second pair's signed_mode must be ignored
    exp_qb.push_back({1'b0, 32'hFFFF_FFD6});
    send(1, 14'h3FFD, 14'd4, 1'b1);
    send(1, 14'd5, 14'h3FFA, 1'b0);
    v_drv = 1'b0;
    tick(4);

    // backpressure across two back-to-back vectors
    rr_drv = 1'b0;
    exp_qb.push_back({1'b0, 32'd140000});
    exp_qb.push_back({1'b0, 32'd3063});
    send(1, 14'd100, 14'd200, 1'b0);
    send(1, 14'd300, 14'd400, 1'b0);
    send(1, 14'd1000, 14'd3, 1'b0);
    send(1, 14'd7, 14'd9, 1'b0);
    v_drv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 33'(if_b.in_ready), 33'd0);
      chk("bp_hold", {if_b.res_valid, if_b.acc_out}, {1'b1, 32'd140000});
      tick(1);
    end
    rr_drv = 1'b1;
    tick(5);

    // saturation vs wrap, then a clean vector to clear the sticky flag
`ifdef AST_MAC_SAT_EN
    exp_qc.push_back({1'b1, 24'd0, 8'd255});
    exp_qc.push_back({1'b1, 24'd0, 8'd127});
`else
    exp_qc.push_back({1'b0, 24'd0, 8'd132});
    exp_qc.push_back({1'b0, 24'd0, 8'd0});
`endif
    exp_qc.push_back({1'b0, 24'd0, 8'd8});
    for (int i = 0; i < 4; i++) send(2, 14'd15, 14'd15, 1'b0);
    for (int i = 0; i < 4; i++) send(2, 14'd8, 14'd8, 1'b1);
    for (int i = 0; i < 4; i++) send(2, 14'd1, 14'd2, 1'b0);
    v_drv = 1'b0;
    tick(4);

    // K_DEPTH = 1 streaming with per-pair signed_mode
    for (int n = 1; n <= 5; n++) exp_qd.push_back({1'b0, 32'(2 * n)});
    exp_qd.push_back({1'b0, 32'hFFFF_FFFE});
    exp_qd.push_back({1'b0, 32'd32766});
    for (int n = 1; n <= 5; n++) send(3, 14'(n), 14'd2, 1'(n % 2));
    send(3, 14'h3FFF, 14'd2, 1'b1);
    send(3, 14'h3FFF, 14'd2, 1'b0);
    v_drv = 1'b0;

    guard = 0;
    while ((exp_qa.size() + exp_qb.size() + exp_qc.size() + exp_qd.size()) != 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    tick(2);
    chk("drain_a", 33'(exp_qa.size()), 33'd0);
    chk("drain_b", 33'(exp_qb.size()), 33'd0);
    chk("drain_c", 33'(exp_qc.size()), 33'd0);
    chk("drain_d", 33'(exp_qd.size()), 33'd0);
    chk("d_result_count", 33'(d_cyc.size()), 33'd7);
    for (int i = 1; i < d_cyc.size(); i++)
      chk("d_back_to_back", 33'(d_cyc[i] - d_cyc[i-1]), 33'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
